// File: rtl/circuit1_pkg.sv
// circuit1_pkg: shared state encoding and widths for the Circuit1 batch accumulator
package circuit1_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
    localparam int SUM_W = 24;
    localparam int CNT_W = 8;
    localparam int BATCH_DEF = 4;
endpackage

// File: rtl/circuit1_minmax.sv
// circuit1_minmax: running max/min of Z over a batch
// Ports: clk, rst (async active-low), load (start a new batch with z),
// update (fold z into the running max/min), z (sample),
// max_next/min_next (value the registers take at the next edge).
module circuit1_minmax (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       update,
    input  logic [7:0] z,
    output logic [7:0] max_next,
    output logic [7:0] min_next
);
    logic [7:0] max_q, min_q;

    // Strict compares keep the held value when z ties it
    always_comb begin
        max_next = load ? z : (update && z > max_q) ? z : max_q;
        min_next = load ? z : (update && z < min_q) ? z : min_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_q <= '0;
            min_q <= '0;
        end else begin
            max_q <= max_next;
            min_q <= min_next;
        end
    end
endmodule

// File: rtl/circuit1_accum.sv
// circuit1_accum: batches BATCH Circuit1 samples and reports sum of X and max/min of Z
// Ports: clk, rst (async active-low), in_valid/in_ready/Z_in/X_in (sample input),
// clr (sync discard of current batch), out_valid/out_ready (result handshake),
// sum_x/max_z/min_z (batch result), batch_cnt (completed batches, wraps).
module circuit1_accum
    import circuit1_pkg::*;
#(
    parameter int BATCH = BATCH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       Z_in,
    input  logic [15:0]      X_in,
    output logic             in_ready,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] sum_x,
    output logic [7:0]       max_z,
    output logic [7:0]       min_z,
    output logic [CNT_W-1:0] batch_cnt
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BATCH - 1);

    state_t           state, state_next;
    logic [SUM_W-1:0] sum_acc, sum_next;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       max_next, min_next;
    logic             accept, load, update, fire, done;

    // in_ready is gated by rst so it reads 0 throughout reset
    assign in_ready  = rst && (state != REPORT);
    assign out_valid = state == REPORT;
    // clr overrides both the accept and the report handshake
    assign accept    = in_valid && in_ready && !clr;
    assign load      = accept && state == IDLE;
    assign update    = accept && state == ACCUM;
    assign fire      = out_valid && out_ready && !clr;
    assign done      = (load && BATCH == 1) || (update && cnt == LAST);

    always_comb begin
        state_next = clr ? IDLE : done ? REPORT : load ? ACCUM : fire ? IDLE : state;
        sum_next   = load ? SUM_W'(X_in) : sum_acc + SUM_W'(X_in);
    end

    circuit1_minmax u_minmax (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .update   (update),
        .z        (Z_in),
        .max_next (max_next),
        .min_next (min_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sum_acc   <= '0;
            sum_x     <= '0;
            max_z     <= '0;
            min_z     <= '0;
            batch_cnt <= '0;
        end else begin
            state <= state_next;
            cnt   <= (clr || fire) ? '0 : load ? CNT_W'(1) : update ? cnt + CNT_W'(1) : cnt;
            if (accept)
                sum_acc <= sum_next;
            // Visible results only move when the batch completes
            if (done) begin
                sum_x <= sum_next;
                max_z <= max_next;
                min_z <= min_next;
            end
            if (fire)
                batch_cnt <= batch_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_circuit1_accum.sv
// tb_circuit1_accum: directed self-checking bench for circuit1_accum (BATCH 4, 1, 255)
module tb_circuit1_accum;
    logic        clk = 0;
    logic        rst = 0;
    logic        in_valid = 0;
    logic [7:0]  Z_in = 0;
    logic [15:0] X_in = 0;
    logic        clr = 0;
    logic        out_ready = 0;

    logic        ir4, ov4, ir1, ov1, ir255, ov255;
    logic [23:0] sx4, sx1, sx255;
    logic [7:0]  mx4, mn4, bc4, mx1, mn1, bc1, mx255, mn255, bc255;

    int pass = 0;
    int total = 0;

    always #5 clk = ~clk;

    circuit1_accum #(.BATCH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .Z_in(Z_in), .X_in(X_in),
        .in_ready(ir4), .clr(clr), .out_valid(ov4), .out_ready(out_ready),
        .sum_x(sx4), .max_z(mx4), .min_z(mn4), .batch_cnt(bc4)
    );
    circuit1_accum #(.BATCH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .Z_in(Z_in), .X_in(X_in),
        .in_ready(ir1), .clr(clr), .out_valid(ov1), .out_ready(out_ready),
        .sum_x(sx1), .max_z(mx1), .min_z(mn1), .batch_cnt(bc1)
    );
    circuit1_accum #(.BATCH(255)) dut255 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .Z_in(Z_in), .X_in(X_in),
        .in_ready(ir255), .clr(clr), .out_valid(ov255), .out_ready(out_ready),
        .sum_x(sx255), .max_z(mx255), .min_z(mn255), .batch_cnt(bc255)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] z, input logic [15:0] x);
        in_valid = 1;
        Z_in = z;
        X_in = x;
        tick();
        in_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        in_valid = 0;
        clr = 0;
        out_ready = 0;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 0;
        #1;
        total++;
        if ({ov4, ir4, sx4, mx4, mn4, bc4} !== {1'b0, 1'b0, 24'd0, 8'd0, 8'd0, 8'd0})
            $display("FAIL reset_state got ov=%0b ir=%0b sum=%0d max=%0d min=%0d bc=%0d exp all 0",
                     ov4, ir4, sx4, mx4, mn4, bc4);
        else pass++;
        @(negedge clk);
        rst = 1;
        tick();
        total++;
        if (ir4 !== 1'b1) $display("FAIL reset_release_ready got %0b exp 1", ir4);
        else pass++;
    endtask

    task automatic test_basic();
        do_reset();
        send(9, 13);
        send(200, 1000);
        send(3, 65535);
        total++;
        if (ov4 !== 1'b0) $display("FAIL basic_early_valid got %0b exp 0", ov4);
        else pass++;
        send(50, 0);
        total++;
        if ({ov4, ir4, sx4, mx4, mn4} !== {1'b1, 1'b0, 24'd66548, 8'd200, 8'd3})
            $display("FAIL basic_result got ov=%0b ir=%0b sum=%0d max=%0d min=%0d exp 1/0/66548/200/3",
                     ov4, ir4, sx4, mx4, mn4);
        else pass++;
    endtask

    task automatic test_hold();
        in_valid = 1;
        Z_in = 77;
        X_in = 777;
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({ov4, ir4, sx4, mx4, mn4} !== {1'b1, 1'b0, 24'd66548, 8'd200, 8'd3})
                $display("FAIL hold_%0d got ov=%0b ir=%0b sum=%0d max=%0d min=%0d exp 1/0/66548/200/3",
                         i, ov4, ir4, sx4, mx4, mn4);
            else pass++;
        end
        in_valid = 0;
        out_ready = 1;
        tick();
        out_ready = 0;
        total++;
        if ({ov4, ir4, bc4, sx4} !== {1'b0, 1'b1, 8'd1, 24'd66548})
            $display("FAIL hold_release got ov=%0b ir=%0b bc=%0d sum=%0d exp 0/1/1/66548",
                     ov4, ir4, bc4, sx4);
        else pass++;
    endtask

    task automatic test_batch1();
        do_reset();
        send(7, 500);
        total++;
        if ({ov1, ir1, sx1, mx1, mn1} !== {1'b1, 1'b0, 24'd500, 8'd7, 8'd7})
            $display("FAIL batch1_result got ov=%0b ir=%0b sum=%0d max=%0d min=%0d exp 1/0/500/7/7",
                     ov1, ir1, sx1, mx1, mn1);
        else pass++;
    endtask

    task automatic test_clr();
        do_reset();
        send(1, 100);
        send(1, 100);
        clr = 1;
        tick();
        clr = 0;
        total++;
        if ({ov4, ir4} !== 2'b01) $display("FAIL clr_idle got ov=%0b ir=%0b exp 0/1", ov4, ir4);
        else pass++;
        send(5, 1);
        send(6, 1);
        send(7, 1);
        total++;
        if (ov4 !== 1'b0) $display("FAIL clr_early_valid got %0b exp 0", ov4);
        else pass++;
        send(8, 1);
        total++;
        if ({ov4, sx4, mx4, mn4} !== {1'b1, 24'd4, 8'd8, 8'd5})
            $display("FAIL clr_result got ov=%0b sum=%0d max=%0d min=%0d exp 1/4/8/5",
                     ov4, sx4, mx4, mn4);
        else pass++;
        clr = 1;
        out_ready = 1;
        tick();
        clr = 0;
        out_ready = 0;
        total++;
        if ({ov4, bc4, sx4, mx4, mn4} !== {1'b0, 8'd0, 24'd4, 8'd8, 8'd5})
            $display("FAIL clr_over_handshake got ov=%0b bc=%0d sum=%0d max=%0d min=%0d exp 0/0/4/8/5",
                     ov4, bc4, sx4, mx4, mn4);
        else pass++;
    endtask

    task automatic test_toggle();
        logic [7:0]  zs [4] = '{8'd10, 8'd20, 8'd5, 8'd15};
        logic [15:0] xs [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            Z_in = in_valid ? zs[i/2] : ((i % 4 == 1) ? 8'd255 : 8'd0);
            X_in = in_valid ? xs[i/2] : 16'd5000;
            tick();
            total++;
            if (ov4 !== (i >= 6)) $display("FAIL toggle_valid_%0d got %0b exp %0b", i, ov4, i >= 6);
            else pass++;
        end
        in_valid = 0;
        total++;
        if ({sx4, mx4, mn4} !== {24'd10, 8'd20, 8'd5})
            $display("FAIL toggle_result got sum=%0d max=%0d min=%0d exp 10/20/5", sx4, mx4, mn4);
        else pass++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        total++;
        if (ov4 !== 1'b1) $display("FAIL areset_pre got %0b exp 1", ov4);
        else pass++;
        #2;
        rst = 0;
        #1;
        total++;
        if ({ov4, ir4, sx4, mx4, mn4, bc4} !== {1'b0, 1'b0, 24'd0, 8'd0, 8'd0, 8'd0})
            $display("FAIL areset_mid got ov=%0b ir=%0b sum=%0d max=%0d min=%0d bc=%0d exp all 0",
                     ov4, ir4, sx4, mx4, mn4, bc4);
        else pass++;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_big();
        do_reset();
        for (int i = 0; i < 255; i++) begin
            send(255, 65535);
            if (i == 253) begin
                total++;
                if (ov255 !== 1'b0) $display("FAIL big_early_valid got %0b exp 0", ov255);
                else pass++;
            end
        end
        total++;
        if ({ov255, sx255, mx255, mn255} !== {1'b1, 24'd16711425, 8'd255, 8'd255})
            $display("FAIL big_result got ov=%0b sum=%0d max=%0d min=%0d exp 1/16711425/255/255",
                     ov255, sx255, mx255, mn255);
        else pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_batch1();
        test_clr();
        test_toggle();
        test_async_reset();
        test_big();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
